// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched requests, fixed priority (line 0 highest), one-cycle TAKE pulse then ISR lockout.
// Latency: edge at t -> pending at t+1 -> TAKE at t+2 given instr_done; no backpressure, reti releases ISR.
module irq_ctrl #(
    parameter int              N_IRQ      = 4,
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] VEC_BASE   = 10'h3C0,
    parameter int              VEC_STRIDE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_in,
    input  logic             gie_set,
    input  logic             gie_clr,
    input  logic             instr_done,
    input  logic             reti,
    output logic             int_take,
    output logic [PC_W-1:0]  int_vec,
    output logic [1:0]       int_id,
    output logic             in_service,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] mask_out,
    output logic             gie
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAKE = 2'd1,
        ISR  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [N_IRQ-1:0] irq_prev;
    logic [N_IRQ-1:0] pending_r;
    logic [N_IRQ-1:0] mask_r;
    logic [N_IRQ-1:0] elig;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr_vec;
    logic             gie_r;
    logic [1:0]       id_r;
    logic [1:0]       winner;
    logic             take_now;
    logic             ret_now;
    logic [PC_W-1:0]  vec_calc;

    assign rise = irq & ~irq_prev;
    assign elig = pending_r & mask_r;

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        winner = 2'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                winner = 2'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        take_now  = 1'b0;
        ret_now   = 1'b0;
        case (state)
            IDLE: begin
                if (gie_r && (|elig) && instr_done) begin
                    take_now  = 1'b1;
                    state_nxt = TAKE;
                end
            end
            TAKE: begin
                state_nxt = ISR;
            end
            ISR: begin
                if (reti) begin
                    ret_now   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // New edges are OR-ed in after the clear, so a fresh edge on the taken line survives.
    assign clr_vec = take_now ? (N_IRQ'(1) << winner) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            irq_prev  <= '0;
            pending_r <= '0;
            mask_r    <= '0;
            gie_r     <= 1'b0;
            id_r      <= 2'd0;
        end else begin
            state     <= state_nxt;
            irq_prev  <= irq;
            pending_r <= (pending_r & ~clr_vec) | rise;
            if (mask_we) begin
                mask_r <= mask_in;
            end
            if (gie_clr) begin
                gie_r <= 1'b0;
            end else if (gie_set) begin
                gie_r <= 1'b1;
            end
            if (take_now) begin
                id_r <= winner;
            end else if (ret_now) begin
                id_r <= 2'd0;
            end
        end
    end

    // Vector sum is truncated to PC_W bits, so large indices wrap silently.
    assign vec_calc   = VEC_BASE + (PC_W'(id_r) * PC_W'(VEC_STRIDE));

    assign int_take   = (state == TAKE);
    assign in_service = (state == TAKE) || (state == ISR);
    assign int_vec    = (state == TAKE) ? vec_calc : '0;
    assign int_id     = id_r;
    assign pending    = pending_r;
    assign mask_out   = mask_r;
    assign gie        = gie_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: per-cycle vector table driven through a scoreboard queue, plus an async reset check.
module tb_irq_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_in;
    logic       gie_set;
    logic       gie_clr;
    logic       instr_done;
    logic       reti;
    logic       int_take;
    logic [9:0] int_vec;
    logic [1:0] int_id;
    logic       in_service;
    logic [3:0] pending;
    logic [3:0] mask_out;
    logic       gie;

    irq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .gie_set    (gie_set),
        .gie_clr    (gie_clr),
        .instr_done (instr_done),
        .reti       (reti),
        .int_take   (int_take),
        .int_vec    (int_vec),
        .int_id     (int_id),
        .in_service (in_service),
        .pending    (pending),
        .mask_out   (mask_out),
        .gie        (gie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] irq;
        logic       mw;
        logic [3:0] mi;
        logic       gs;
        logic       gc;
        logic       idn;
        logic       rt;
    } in_t;

    typedef struct {
        logic       tk;
        logic [9:0] vec;
        logic [1:0] id;
        logic       is;
        logic [3:0] pd;
        logic [3:0] mk;
        logic       g;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t tbl[$];
    out_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_row  = 0;

    task automatic add(input logic [3:0] a_irq, input logic a_mw, input logic [3:0] a_mi,
                       input logic a_gs, input logic a_gc, input logic a_idn, input logic a_rt,
                       input logic e_tk, input logic [9:0] e_vec, input logic [1:0] e_id,
                       input logic e_is, input logic [3:0] e_pd, input logic [3:0] e_mk,
                       input logic e_g);
        vec_t v;
        v.i.irq = a_irq; v.i.mw = a_mw; v.i.mi = a_mi; v.i.gs = a_gs;
        v.i.gc = a_gc; v.i.idn = a_idn; v.i.rt = a_rt;
        v.o.tk = e_tk; v.o.vec = e_vec; v.o.id = e_id; v.o.is = e_is;
        v.o.pd = e_pd; v.o.mk = e_mk; v.o.g = e_g;
        tbl.push_back(v);
    endtask

    task automatic check(input string name);
        out_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, no expected value", name);
        end else begin
            e = sb.pop_front();
            n_vec++;
            if (int_take !== e.tk || int_vec !== e.vec || int_id !== e.id || in_service !== e.is ||
                pending !== e.pd || mask_out !== e.mk || gie !== e.g) begin
                n_fail++;
                $display("FAIL %s: got take=%b vec=%h id=%0d insvc=%b pend=%b mask=%b gie=%b, want take=%b vec=%h id=%0d insvc=%b pend=%b mask=%b gie=%b",
                         name, int_take, int_vec, int_id, in_service, pending, mask_out, gie,
                         e.tk, e.vec, e.id, e.is, e.pd, e.mk, e.g);
            end
        end
    endtask

    task automatic expect_zero();
        out_t z;
        z.tk = 1'b0; z.vec = '0; z.id = '0; z.is = 1'b0; z.pd = '0; z.mk = '0; z.g = 1'b0;
        sb.push_back(z);
    endtask

    task automatic drive_idle();
        irq = '0; mask_we = 1'b0; mask_in = '0; gie_set = 1'b0;
        gie_clr = 1'b0; instr_done = 1'b0; reti = 1'b0;
    endtask

    task automatic run_table();
        vec_t v;
        while (tbl.size() > 0) begin
            v = tbl.pop_front();
            @(negedge clk);
            irq = v.i.irq; mask_we = v.i.mw; mask_in = v.i.mi; gie_set = v.i.gs;
            gie_clr = v.i.gc; instr_done = v.i.idn; reti = v.i.rt;
            sb.push_back(v.o);
            @(posedge clk);
            #1;
            check($sformatf("row%0d", n_row));
            n_row++;
        end
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        #1;
        expect_zero();
        check("reset_state");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic take on line 2.
        add(4'h0, 1, 4'hF, 1, 0, 1, 0,  0, 10'h000, 0, 0, 4'h0, 4'hF, 1);
        add(4'h4, 0, 4'h0, 0, 0, 1, 0,  0, 10'h000, 0, 0, 4'h4, 4'hF, 1);
        add(4'h4, 0, 4'h0, 0, 0, 1, 0,  1, 10'h3C8, 2, 1, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 1, 0,  0, 10'h000, 2, 1, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1,  0, 10'h000, 0, 0, 4'h0, 4'hF, 1);
        // Priority: lines 1 and 3 together.
        add(4'hA, 0, 4'h0, 0, 0, 0, 0,  0, 10'h000, 0, 0, 4'hA, 4'hF, 1);
        add(4'hA, 0, 4'h0, 0, 0, 1, 0,  1, 10'h3C4, 1, 1, 4'h8, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 0,  0, 10'h000, 1, 1, 4'h8, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1,  0, 10'h000, 0, 0, 4'h8, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 1, 0,  1, 10'h3CC, 3, 1, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 1, 0,  0, 10'h000, 3, 1, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1,  0, 10'h000, 0, 0, 4'h0, 4'hF, 1);
        // Masked line 0 latches but is not taken until unmasked.
        add(4'h0, 1, 4'hE, 0, 0, 1, 0,  0, 10'h000, 0, 0, 4'h0, 4'hE, 1);
        add(4'h1, 0, 4'h0, 0, 0, 1, 0,  0, 10'h000, 0, 0, 4'h1, 4'hE, 1);
        add(4'h1, 0, 4'h0, 0, 0, 1, 0,  0, 10'h000, 0, 0, 4'h1, 4'hE, 1);
        add(4'h0, 0, 4'h0, 0, 0, 1, 0,  0, 10'h000, 0, 0, 4'h1, 4'hE, 1);
        add(4'h0, 1, 4'hF, 0, 0, 1, 0,  0, 10'h000, 0, 0, 4'h1, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 1, 0,  1, 10'h3C0, 0, 1, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 1, 0,  0, 10'h000, 0, 1, 4'h0, 4'hF, 1);
        // Edge during ISR stays pending until after return.
        add(4'h1, 0, 4'h0, 0, 0, 1, 0,  0, 10'h000, 0, 1, 4'h1, 4'hF, 1);
        add(4'h0, 0, 4'h0, 1, 0, 1, 0,  0, 10'h000, 0, 1, 4'h1, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 1, 1,  0, 10'h000, 0, 0, 4'h1, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 1, 0,  1, 10'h3C0, 0, 1, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 1, 0,  0, 10'h000, 0, 1, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1,  0, 10'h000, 0, 0, 4'h0, 4'hF, 1);
        // gie_set with gie_clr: clear wins.
        add(4'h0, 0, 4'h0, 1, 1, 1, 0,  0, 10'h000, 0, 0, 4'h0, 4'hF, 0);
        // Boundary wait: eligible but no instr_done for 5 cycles.
        add(4'h4, 0, 4'h0, 1, 0, 0, 0,  0, 10'h000, 0, 0, 4'h4, 4'hF, 1);
        for (int k = 0; k < 5; k++)
            add(4'h0, 0, 4'h0, 0, 0, 0, 0,  0, 10'h000, 0, 0, 4'h4, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 1, 0,  1, 10'h3C8, 2, 1, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 0,  0, 10'h000, 2, 1, 4'h0, 4'hF, 1);
        add(4'h8, 0, 4'h0, 0, 0, 0, 0,  0, 10'h000, 2, 1, 4'h8, 4'hF, 1);
        run_table();

        // Asynchronous reset in ISR with pending=1000: outputs clear before any edge.
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        #1;
        expect_zero();
        check("reset_async");
        @(posedge clk);
        #1;
        expect_zero();
        check("reset_held");
        @(negedge clk);
        reset = 1'b0;

        // After reset: no take until a new edge.
        add(4'h0, 1, 4'hF, 1, 0, 1, 0,  0, 10'h000, 0, 0, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 1, 0,  0, 10'h000, 0, 0, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 1, 0,  0, 10'h000, 0, 0, 4'h0, 4'hF, 1);
        add(4'h8, 0, 4'h0, 0, 0, 0, 0,  0, 10'h000, 0, 0, 4'h8, 4'hF, 1);
        add(4'h8, 0, 4'h0, 0, 0, 1, 0,  1, 10'h3CC, 3, 1, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 0,  0, 10'h000, 3, 1, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1,  0, 10'h000, 0, 0, 4'h0, 4'hF, 1);
        // reti in IDLE is ignored.
        add(4'h0, 0, 4'h0, 0, 0, 0, 1,  0, 10'h000, 0, 0, 4'h0, 4'hF, 1);
        // New edge on the line being taken keeps it pending.
        add(4'h4, 0, 4'h0, 0, 0, 0, 0,  0, 10'h000, 0, 0, 4'h4, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 0,  0, 10'h000, 0, 0, 4'h4, 4'hF, 1);
        add(4'h4, 0, 4'h0, 0, 0, 1, 0,  1, 10'h3C8, 2, 1, 4'h4, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 0,  0, 10'h000, 2, 1, 4'h4, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1,  0, 10'h000, 0, 0, 4'h4, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 1, 0,  1, 10'h3C8, 2, 1, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 0,  0, 10'h000, 2, 1, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0, 1,  0, 10'h000, 0, 0, 4'h0, 4'hF, 1);
        run_table();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller for the 16-bit CPU.
- Latches rising edges on external request lines and prioritises them among enabled, unmasked sources.
- At an instruction boundary, sequences the datapath for one cycle: the PC mux selects the vector, and the stack pushes the return PC.
- Blocks further interrupts until the control unit decodes a return-from-interrupt.

Parameters:
N_IRQ, 4, number of request lines; line 0 has highest priority.
PC_W, 10, PC/jump address width.
VEC_BASE, 10'h3C0, vector address of line 0.
VEC_STRIDE, 4, address spacing between consecutive vectors.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
irq  in  N_IRQ  request lines, synchronous to clk; a 0->1 transition is a request.
mask_we  in  1  load mask register from mask_in.
mask_in  in  N_IRQ  new mask value; 1 = line enabled.
gie_set  in  1  set global interrupt enable.
gie_clr  in  1  clear global interrupt enable.
instr_done  in  1  current instruction completes this cycle (PC advances).
reti  in  1  one-cycle pulse from the control unit on return-from-interrupt, coincident with its stack pop.
int_take  out  1  one-cycle pulse: PC mux selects int_vec; stack pushes the return PC.
int_vec  out  PC_W  vector address, valid while int_take=1.
int_id  out  2  index of the source being serviced; valid in TAKE and ISR, otherwise 0.
in_service  out  1  high from the TAKE state until the cycle after the accepted reti.
pending  out  N_IRQ  latched pending requests.
mask_out  out  N_IRQ  current mask register.
gie  out  1  global enable.

Behaviour:
- Reset (asynchronous, any state, including mid-ISR): state=IDLE; pending, mask, gie, irq_prev, int_id, int_take and in_service all 0. Pending requests are discarded.
- Edge detect: irq_prev <= irq every cycle. A rising edge is irq & ~irq_prev.
- Pending bit set: on a rising edge, the bit sets in the next cycle.
- Pending bit clear: the bit clears only when its source is taken.
- Simultaneous clear and new edge on the same bit: set wins; the bit stays pending.
- Masked lines: still latch into pending, but are not eligible.
- Eligibility: elig = pending & mask_out. Winner = lowest index set in elig.
- Vector arithmetic: int_vec = VEC_BASE + winner*VEC_STRIDE, computed modulo 2^PC_W (wraps silently).
- gie_set/gie_clr asserted together: clear wins. mask_we takes effect in the next cycle.
- State IDLE:
  - Enter TAKE at the next edge if gie & |elig & instr_done.
  - In the same transition, latch int_id=winner and clear pending[winner].
  - reti in IDLE is ignored.
- State TAKE (exactly one cycle):
  - int_take=1, in_service=1, int_vec driven from the latched int_id.
  - Unconditionally goes to ISR.
- State ISR:
  - in_service=1; no new take, whatever the pending/gie/mask values.
  - reti -> IDLE. int_id returns to 0 on the transition.
- New take after return: IDLE may start a new take no earlier than the cycle after returning. There is no back-to-back TAKE.
- Latency: edge sampled at cycle t -> pending at t+1 -> TAKE at t+2 if instr_done=1 at t+1. Otherwise TAKE comes one cycle after the first qualifying instr_done.
- Outputs: int_take, int_vec and in_service are Moore outputs of the state register (glitch-free). int_vec = 0 outside TAKE.
- Nesting: not supported. gie is not modified by the controller; software manages it.

Test Plan:
- Basic take: reset; mask=4'b1111; gie_set; rising edge on irq[2]; instr_done held 1 -> pending=4'b0100 next cycle; int_take pulse one cycle later with int_vec=10'h3C8, int_id=2; pending returns to 0.
- Priority: edges on irq[1] and irq[3] in the same cycle -> first take has int_vec=10'h3C4, int_id=1. After reti, second take has int_vec=10'h3CC, int_id=3.
- Mask and gie:
  - mask=4'b1110, edge on irq[0] -> pending[0]=1 and no take. Writing mask=4'b1111 then produces a take to 10'h3C0.
  - gie_set and gie_clr together -> gie=0.
- Blocking in ISR: edge on irq[0] while in ISR -> pending[0]=1 and no int_take until reti. The take occurs at the earliest one cycle after returning to IDLE.
- Boundary wait: pending eligible but instr_done=0 for 5 cycles -> no int_take. int_take follows the first instr_done by one cycle.
- Reset mid-ISR: assert reset in ISR with pending=4'b1000 -> all outputs 0 immediately (asynchronous). After release there is no take until a new edge arrives.
